// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the L2 arbiter (line, word, arbiter state, wait ceiling).
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } l2_arb_state;

  localparam lc3b_word L2_ARB_WAIT_MAX = 16'hFFFF;

endpackage

// File: rtl/l2_arbiter_mux.sv
// Combinational routing between the two L1 caches and the L2 port, keyed by
// the arbiter state. The ungranted side always sees resp=0 and rdata=0.
module l2_arbiter_mux
  import lc3b_types::*;
(
  input  l2_arb_state state,
  input  logic        i_read,
  input  lc3b_word    i_address,
  output lc3b_block   i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  lc3b_word    d_address,
  input  lc3b_block   d_wdata,
  output lc3b_block   d_rdata,
  output logic        d_resp,
  output logic        l2_read,
  output logic        l2_write,
  output lc3b_word    l2_address,
  output lc3b_block   l2_wdata,
  input  lc3b_block   l2_rdata,
  input  logic        l2_resp
);

  // Forward the granted requester to L2 and steer the response back to it.
  always_comb begin
    i_rdata    = '0;
    i_resp     = 1'b0;
    d_rdata    = '0;
    d_resp     = 1'b0;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    case (state)
      ARB_SERVE_I: begin
        l2_read    = i_read;
        l2_address = i_address;
        i_resp     = l2_resp;
        i_rdata    = l2_rdata;
      end
      ARB_SERVE_D: begin
        l2_read    = d_read;
        l2_write   = d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        d_resp     = l2_resp;
        d_rdata    = l2_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/l2_arbiter.sv
// L2 port arbiter between icache and dcache: three-state grant FSM plus a
// saturating wait-cycle counter. Define L2_ARB_ROUND_ROBIN_EN to alternate
// tie winners; otherwise dcache always wins a tie.
module l2_arbiter
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_read,
  input  lc3b_word  i_address,
  output lc3b_block i_rdata,
  output logic      i_resp,
  input  logic      d_read,
  input  logic      d_write,
  input  lc3b_word  d_address,
  input  lc3b_block d_wdata,
  output lc3b_block d_rdata,
  output logic      d_resp,
  output logic      l2_read,
  output logic      l2_write,
  output lc3b_word  l2_address,
  output lc3b_block l2_wdata,
  input  lc3b_block l2_rdata,
  input  logic      l2_resp,
  input  logic      wait_clear,
  output lc3b_word  wait_count
);

  l2_arb_state state_q, state_d;
  lc3b_word    wait_q, wait_d;
  logic        gap_q;       // current IDLE cycle directly follows a grant
  logic        d_req;
  logic        i_wins_tie;
  logic        i_wait, d_wait;

  assign d_req = d_read | d_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;  // 0 = icache, 1 = dcache

  // Remember which side received the most recent grant.
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ARB_IDLE && state_d == ARB_SERVE_I) last_grant_d = 1'b0;
    if (state_q == ARB_IDLE && state_d == ARB_SERVE_D) last_grant_d = 1'b1;
  end

  // Last-grant register.
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b0;
    else       last_grant_q <= last_grant_d;
  end

  assign i_wins_tie = last_grant_q;
`else
  assign i_wins_tie = 1'b0;
`endif

  // Grant FSM next state; a SERVE state is left only on the L2 response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_read && d_req) state_d = i_wins_tie ? ARB_SERVE_I : ARB_SERVE_D;
        else if (i_read)     state_d = ARB_SERVE_I;
        else if (d_req)      state_d = ARB_SERVE_D;
      end
      ARB_SERVE_I: if (l2_resp) state_d = ARB_IDLE;
      ARB_SERVE_D: if (l2_resp) state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // A requester waits when the other side is served, when it loses an IDLE
  // tie, or during the mandatory gap after a grant. A fresh lone request
  // granted straight from IDLE does not count as waiting.
  always_comb begin
    i_wait = i_read && ((state_q == ARB_SERVE_D) ||
             (state_q == ARB_IDLE && (gap_q || state_d != ARB_SERVE_I)));
    d_wait = d_req && ((state_q == ARB_SERVE_I) ||
             (state_q == ARB_IDLE && (gap_q || state_d != ARB_SERVE_D)));
    wait_d = wait_q;
    if (wait_clear)                                        wait_d = '0;
    else if ((i_wait || d_wait) && wait_q != L2_ARB_WAIT_MAX) wait_d = wait_q + 16'd1;
  end

  // State, gap flag and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      gap_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= (state_q != ARB_IDLE);
      wait_q  <= wait_d;
    end
  end

  assign wait_count = wait_q;

  l2_arbiter_mux u_mux (
    .state      (state_q),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_rdata   (l2_rdata),
    .l2_resp    (l2_resp)
  );

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter; expected tie order follows L2_ARB_ROUND_ROBIN_EN.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read, d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         l2_read, l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;
  logic         wait_clear;
  logic [15:0]  wait_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  l2_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_rdata   (l2_rdata),
    .l2_resp    (l2_resp),
    .wait_clear (wait_clear),
    .wait_count (wait_count)
  );

  // Advance one cycle; inputs are then changed and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; i_address = 0; d_read = 0; d_write = 0; d_address = 0;
    d_wdata = 0; l2_rdata = 0; l2_resp = 0; wait_clear = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    settle();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 0000", {l2_read, l2_write, i_resp, d_resp});
    end
    n_cmp++;
    if (wait_count !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_wait: got %h required 0000", wait_count);
    end
  endtask

  task automatic test_icache_fill();
    apply_reset();
    i_read = 1; i_address = 16'h0040; settle();      // cycle 0, IDLE
    n_cmp++;
    if (l2_read !== 1'b0) begin
      n_bad++; $display("FAIL ifill_idle_l2read: got %b required 0", l2_read);
    end
    tick();                                          // cycle 1, SERVE_I
    n_cmp++;
    if (l2_read !== 1'b1 || l2_address !== 16'h0040 || l2_write !== 1'b0) begin
      n_bad++;
      $display("FAIL ifill_req: got rd=%b wr=%b addr=%h required rd=1 wr=0 addr=0040",
               l2_read, l2_write, l2_address);
    end
    tick(); tick();                                  // cycle 3
    n_cmp++;
    if (i_resp !== 1'b0) begin
      n_bad++; $display("FAIL ifill_early_resp: got %b required 0", i_resp);
    end
    tick();                                          // cycle 4, L2 responds
    l2_resp = 1; l2_rdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1111_2222; settle();
    n_cmp++;
    if (i_resp !== 1'b1 || i_rdata !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1111_2222) begin
      n_bad++; $display("FAIL ifill_resp: got resp=%b data=%h required resp=1", i_resp, i_rdata);
    end
    n_cmp++;
    if (d_resp !== 1'b0 || d_rdata !== 128'h0) begin
      n_bad++; $display("FAIL ifill_d_quiet: got resp=%b data=%h required 0/0", d_resp, d_rdata);
    end
    tick();
    i_read = 0; l2_resp = 0; settle();               // cycle 5, IDLE
    n_cmp++;
    if (l2_read !== 1'b0 || wait_count !== 16'h0000) begin
      n_bad++;
      $display("FAIL ifill_done: got rd=%b wait=%h required rd=0 wait=0000", l2_read, wait_count);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    i_read = 1; i_address = 16'h0040;
    d_write = 1; d_address = 16'h0080; d_wdata = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
    settle();                                        // cycle 0, tie
    tick();                                          // cycle 1, SERVE_D
    l2_rdata = 128'h7777; settle();
    n_cmp++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_address !== 16'h0080 ||
        l2_wdata !== 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F) begin
      n_bad++;
      $display("FAIL tie_serve_d: got wr=%b rd=%b addr=%h wdata=%h required wr=1 rd=0 addr=0080",
               l2_write, l2_read, l2_address, l2_wdata);
    end
    n_cmp++;
    if (i_rdata !== 128'h0 || i_resp !== 1'b0) begin
      n_bad++; $display("FAIL tie_i_quiet: got resp=%b data=%h required 0/0", i_resp, i_rdata);
    end
    tick(); tick();                                  // cycle 3, L2 responds
    l2_resp = 1; l2_rdata = 128'h55; settle();
    n_cmp++;
    if (d_resp !== 1'b1 || d_rdata !== 128'h55 || i_resp !== 1'b0) begin
      n_bad++; $display("FAIL tie_d_resp: got d=%b data=%h i=%b required 1/55/0",
                        d_resp, d_rdata, i_resp);
    end
    tick();
    d_write = 0; l2_resp = 0; settle();              // cycle 4, mandatory IDLE
    n_cmp++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
      n_bad++; $display("FAIL tie_gap: got rd=%b wr=%b required 0/0", l2_read, l2_write);
    end
    tick();                                          // cycle 5, SERVE_I
    n_cmp++;
    if (l2_read !== 1'b1 || l2_address !== 16'h0040) begin
      n_bad++; $display("FAIL tie_then_i: got rd=%b addr=%h required 1/0040", l2_read, l2_address);
    end
    n_cmp++;
    if (wait_count !== 16'd5) begin                  // I waited cycles 0..4
      n_bad++; $display("FAIL tie_wait: got %0d required 5", wait_count);
    end
    tick();
    l2_resp = 1; settle();
    tick();
    i_read = 0; l2_resp = 0; settle();
  endtask

  task automatic test_back_to_back();
    logic [2:0] order;   // 1 = D granted
    logic [2:0] exp_order;
`ifdef L2_ARB_ROUND_ROBIN_EN
    exp_order = 3'b101;
`else
    exp_order = 3'b111;
`endif
    order = 3'b000;
    apply_reset();
    i_read = 1; d_read = 1; i_address = 16'h0100; d_address = 16'h0200; settle();
    for (int g = 0; g < 3; g++) begin
      tick();                                        // grant cycle
      l2_resp = 1; settle();
      n_cmp++;
      if ((i_resp ^ d_resp) !== 1'b1 || l2_read !== 1'b1) begin
        n_bad++; $display("FAIL b2b_grant%0d: got i=%b d=%b rd=%b required exactly one resp",
                          g, i_resp, d_resp, l2_read);
      end
      order[2-g] = d_resp;
      tick();                                        // IDLE gap
      l2_resp = 0; settle();
    end
    n_cmp++;
    if (order !== exp_order) begin
      n_bad++; $display("FAIL b2b_order: got %b required %b (1=D)", order, exp_order);
    end
    i_read = 0; d_read = 0; settle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_read = 1; i_address = 16'h0040; settle();
    tick();
    n_cmp++;
    if (l2_read !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_pre: got %b required 1", l2_read);
    end
    reset = 1; settle();
    tick();
    reset = 0; i_read = 0; l2_resp = 1; l2_rdata = 128'h99; settle();
    n_cmp++;
    if (l2_read !== 1'b0 || i_resp !== 1'b0 || i_rdata !== 128'h0) begin
      n_bad++; $display("FAIL rst_mid_after: got rd=%b resp=%b data=%h required 0/0/0",
                        l2_read, i_resp, i_rdata);
    end
    n_cmp++;
    if (wait_count !== 16'h0000) begin
      n_bad++; $display("FAIL rst_mid_wait: got %h required 0000", wait_count);
    end
    tick();
    l2_resp = 0; settle();
  endtask

  task automatic test_saturation();
    apply_reset();
    i_read = 1; d_read = 1; settle();                // D granted, I waits, no L2 resp
    for (int c = 0; c < 65540; c++) tick();
    n_cmp++;
    if (wait_count !== 16'hFFFF) begin
      n_bad++; $display("FAIL sat_reach: got %h required FFFF", wait_count);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (wait_count !== 16'hFFFF) begin
      n_bad++; $display("FAIL sat_hold: got %h required FFFF", wait_count);
    end
    wait_clear = 1; settle();
    tick();
    wait_clear = 0; settle();
    n_cmp++;
    if (wait_count !== 16'h0000) begin
      n_bad++; $display("FAIL sat_clear: got %h required 0000", wait_count);
    end
    tick();
    n_cmp++;
    if (wait_count !== 16'h0001) begin
      n_bad++; $display("FAIL sat_resume: got %h required 0001", wait_count);
    end
    idle_inputs(); settle();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    tick();
    test_reset();
    test_icache_fill();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
